// File: rtl/proc_io_port.sv
// proc_io_port: word-level I/O port for the 16-bit core.
// Show-ahead input FIFO feeding din; output FIFO drained from dout.
module proc_io_port #(
  parameter int DATA_W    = 16,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8,
  localparam int ICW = $clog2(IN_DEPTH + 1),
  localparam int OCW = $clog2(OUT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] din,
  output logic              din_valid,
  input  logic              din_rd,
  input  logic [DATA_W-1:0] dout,
  input  logic              dout_wr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ICW-1:0]    in_count,
  output logic [OCW-1:0]    out_count,
  output logic              unf_err,
  output logic              ovf_err
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [ICW-1:0] IFULL = ICW'(IN_DEPTH);
  localparam logic [OCW-1:0] OFULL = OCW'(OUT_DEPTH);

  logic [DATA_W-1:0] r_in_mem [IN_DEPTH];
  logic [IAW-1:0]    r_in_wr;
  logic [IAW-1:0]    r_in_rd;
  logic [ICW-1:0]    r_in_cnt;
  logic              r_unf;

  logic [DATA_W-1:0] r_out_mem [OUT_DEPTH];
  logic [OAW-1:0]    r_out_wr;
  logic [OAW-1:0]    r_out_rd;
  logic [OCW-1:0]    r_out_cnt;
  logic              r_ovf;

  logic w_in_push;
  logic w_in_pop;
  logic w_in_empty;
  logic w_out_push;
  logic w_out_pop;
  logic w_out_full;
  logic w_out_empty;

  assign w_in_empty  = (r_in_cnt == '0);
  assign w_out_empty = (r_out_cnt == '0);
  assign w_out_full  = (r_out_cnt == OFULL);

  assign s_ready   = (r_in_cnt != IFULL);
  assign din_valid = !w_in_empty;
  assign din       = w_in_empty ? '0 : r_in_mem[r_in_rd];
  assign m_valid   = !w_out_empty;
  assign m_data    = w_out_empty ? '0 : r_out_mem[r_out_rd];
  assign in_count  = r_in_cnt;
  assign out_count = r_out_cnt;
  assign unf_err   = r_unf;
  assign ovf_err   = r_ovf;

  assign w_in_push  = s_valid && s_ready;
  assign w_in_pop   = din_rd && !w_in_empty;
  assign w_out_push = dout_wr && !w_out_full;
  assign w_out_pop  = m_ready && !w_out_empty;

  // Input FIFO storage: write the producer word at the tail.
  always_ff @(posedge clk) begin
    if (!sys_rst && w_in_push) begin
      r_in_mem[r_in_wr] <= s_data;
    end
  end

  // Input FIFO pointers, occupancy and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_in_wr  <= '0;
      r_in_rd  <= '0;
      r_in_cnt <= '0;
      r_unf    <= 1'b0;
    end else begin
      if (w_in_push) begin
        r_in_wr <= r_in_wr + IAW'(1);
      end
      if (w_in_pop) begin
        r_in_rd <= r_in_rd + IAW'(1);
      end
      case ({w_in_push, w_in_pop})
        2'b10:   r_in_cnt <= r_in_cnt + ICW'(1);
        2'b01:   r_in_cnt <= r_in_cnt - ICW'(1);
        default: r_in_cnt <= r_in_cnt;
      endcase
      if (din_rd && w_in_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Output FIFO storage: write the core word at the tail.
  always_ff @(posedge clk) begin
    if (!sys_rst && w_out_push) begin
      r_out_mem[r_out_wr] <= dout;
    end
  end

  // Output FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_out_wr  <= '0;
      r_out_rd  <= '0;
      r_out_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_out_push) begin
        r_out_wr <= r_out_wr + OAW'(1);
      end
      if (w_out_pop) begin
        r_out_rd <= r_out_rd + OAW'(1);
      end
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_cnt <= r_out_cnt + OCW'(1);
        2'b01:   r_out_cnt <= r_out_cnt - OCW'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
      if (dout_wr && w_out_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_proc_io_port.sv
// tb_proc_io_port: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_proc_io_port;

  localparam int DW  = 16;
  localparam int IND = 8;
  localparam int OUD = 8;
  localparam int ICW = $clog2(IND + 1);
  localparam int OCW = $clog2(OUD + 1);

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_rd = 1'b0;
  logic [DW-1:0] dout = '0;
  logic          dout_wr = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [ICW-1:0] in_count;
  logic [OCW-1:0] out_count;
  logic          unf_err;
  logic          ovf_err;

  proc_io_port #(
    .DATA_W(DW), .IN_DEPTH(IND), .OUT_DEPTH(OUD)
  ) dut (
    .clk(clk), .sys_rst(sys_rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .din(din), .din_valid(din_valid), .din_rd(din_rd),
    .dout(dout), .dout_wr(dout_wr),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .in_count(in_count), .out_count(out_count),
    .unf_err(unf_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] iq[$];
  logic [DW-1:0] oq[$];
  logic          m_unf = 1'b0;
  logic          m_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: advance queues using the values about to be sampled.
  task automatic model_step();
    bit ipush, ipop, opush, opop;
    if (sys_rst) begin
      iq.delete();
      oq.delete();
      m_unf = 1'b0;
      m_ovf = 1'b0;
      return;
    end
    ipush = s_valid && (iq.size() != IND);
    ipop  = din_rd && (iq.size() > 0);
    if (din_rd && iq.size() == 0) m_unf = 1'b1;
    opush = dout_wr && (oq.size() != OUD);
    opop  = m_ready && (oq.size() > 0);
    if (dout_wr && oq.size() == OUD) m_ovf = 1'b1;
    if (ipop) void'(iq.pop_front());
    if (ipush) iq.push_back(s_data);
    if (opop) void'(oq.pop_front());
    if (opush) oq.push_back(dout);
  endtask

  task automatic model_check();
    chk("s_ready", 32'(s_ready), 32'(iq.size() != IND));
    chk("din_valid", 32'(din_valid), 32'(iq.size() > 0));
    chk("din", 32'(din), (iq.size() > 0) ? 32'(iq[0]) : 32'd0);
    chk("in_count", 32'(in_count), 32'(iq.size()));
    chk("m_valid", 32'(m_valid), 32'(oq.size() > 0));
    chk("m_data", 32'(m_data), (oq.size() > 0) ? 32'(oq[0]) : 32'd0);
    chk("out_count", 32'(out_count), 32'(oq.size()));
    chk("unf_err", 32'(unf_err), 32'(m_unf));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle_inputs();
    s_valid = 1'b0; din_rd = 1'b0;
    dout_wr = 1'b0; m_ready = 1'b0;
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          rd;
    logic          wr;
    logic [DW-1:0] wd;
    logic          mr;
    int            e_icnt;
    logic [DW-1:0] e_din;
    int            e_ocnt;
    logic [DW-1:0] e_m;
  } vec_t;

  vec_t tbl[11];
  logic [DW-1:0] got;

  initial begin
    tbl[0]  = '{1, 16'h1111, 0, 0, 16'h0000, 0, 1, 16'h1111, 0, 16'h0000};
    tbl[1]  = '{1, 16'h2222, 0, 0, 16'h0000, 0, 2, 16'h1111, 0, 16'h0000};
    tbl[2]  = '{1, 16'h3333, 0, 0, 16'h0000, 0, 3, 16'h1111, 0, 16'h0000};
    tbl[3]  = '{0, 16'h0000, 1, 0, 16'h0000, 0, 2, 16'h2222, 0, 16'h0000};
    tbl[4]  = '{0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h3333, 0, 16'h0000};
    tbl[5]  = '{0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
    tbl[6]  = '{0, 16'h0000, 0, 1, 16'h00AA, 0, 0, 16'h0000, 1, 16'h00AA};
    tbl[7]  = '{1, 16'h4444, 0, 1, 16'h00BB, 0, 1, 16'h4444, 2, 16'h00AA};
    tbl[8]  = '{1, 16'h5555, 1, 0, 16'h0000, 1, 1, 16'h5555, 1, 16'h00BB};
    tbl[9]  = '{0, 16'h0000, 0, 1, 16'h00CC, 1, 1, 16'h5555, 1, 16'h00CC};
    tbl[10] = '{0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000};

    // Reset then idle
    sys_rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 5; i++) cycle();
    sys_rst = 1'b0;
    cycle();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_din_valid", 32'(din_valid), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_counts", 32'({in_count, out_count}), 32'd0);
    chk("rst_flags", 32'({unf_err, ovf_err}), 32'd0);

    // Table-driven vectors: ordering and simultaneous push/pop
    for (int i = 0; i < 11; i++) begin
      s_valid = tbl[i].sv; s_data = tbl[i].sd;
      din_rd = tbl[i].rd; dout_wr = tbl[i].wr;
      dout = tbl[i].wd; m_ready = tbl[i].mr;
      cycle();
      chk($sformatf("tbl%0d_icnt", i), 32'(in_count), 32'(tbl[i].e_icnt));
      chk($sformatf("tbl%0d_din", i), 32'(din), 32'(tbl[i].e_din));
      chk($sformatf("tbl%0d_ocnt", i), 32'(out_count), 32'(tbl[i].e_ocnt));
      chk($sformatf("tbl%0d_m", i), 32'(m_data), 32'(tbl[i].e_m));
    end
    idle_inputs();
    chk("tbl_no_flags", 32'({unf_err, ovf_err}), 32'd0);

    // Input full, then sustained push/pop across pointer wrap
    for (int i = 0; i < IND + 2; i++) begin
      s_valid = 1'b1; s_data = DW'(16'h0100 + i);
      cycle();
    end
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("full_count", 32'(in_count), 32'(IND));
    chk("full_head", 32'(din), 32'h0100);
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = DW'(16'h0200 + i);
      din_rd = 1'b1;
      cycle();
    end
    idle_inputs();
    din_rd = 1'b1;
    for (int i = 0; i < IND + 1; i++) cycle();
    chk("drain_count", 32'(in_count), 32'd0);

    // Underflow: sticky until reset
    din_rd = 1'b1;
    cycle();
    din_rd = 1'b0;
    chk("unf_set", 32'(unf_err), 32'd1);
    chk("unf_cnt", 32'(in_count), 32'd0);
    for (int i = 0; i < 3; i++) cycle();
    chk("unf_sticky", 32'(unf_err), 32'd1);

    // Output overflow: ninth word dropped
    for (int i = 1; i <= 9; i++) begin
      dout_wr = 1'b1; dout = DW'(i);
      cycle();
    end
    dout_wr = 1'b0;
    chk("ovf_count", 32'(out_count), 32'd8);
    chk("ovf_flag", 32'(ovf_err), 32'd1);
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      got = m_data;
      chk($sformatf("drain_%0d", i), 32'(got), 32'(i));
      cycle();
    end
    chk("drain_empty", 32'(m_valid), 32'd0);
    m_ready = 1'b0;

    // Overflow while popping in the same cycle: still dropped
    for (int i = 0; i < OUD; i++) begin
      dout_wr = 1'b1; dout = DW'(16'h0A00 + i);
      cycle();
    end
    dout = 16'hDEAD; m_ready = 1'b1;
    cycle();
    dout_wr = 1'b0; m_ready = 1'b0;
    chk("ovf_pop_cnt", 32'(out_count), 32'(OUD - 1));

    // Reset mid-operation with both FIFOs half full
    sys_rst = 1'b1; cycle(); sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = DW'(16'h7000 + i);
      dout_wr = 1'b1; dout = DW'(16'h8000 + i);
      cycle();
    end
    din_rd = 1'b1; m_ready = 1'b1;
    s_data = 16'h7777; dout = 16'h8888;
    sys_rst = 1'b1;
    cycle();
    chk("mid_rst_cnt", 32'({in_count, out_count}), 32'd0);
    chk("mid_rst_valid", 32'({din_valid, m_valid}), 32'd0);
    sys_rst = 1'b0;
    idle_inputs();
    cycle();
    chk("mid_rst_din", 32'(din), 32'd0);
    chk("mid_rst_m", 32'(m_data), 32'd0);
    chk("mid_rst_flags", 32'({unf_err, ovf_err}), 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      s_valid = 1'($urandom_range(0, 3) != 0);
      s_data = DW'($urandom);
      din_rd = 1'($urandom_range(0, 2) == 0);
      dout_wr = 1'($urandom_range(0, 2) != 0);
      dout = DW'($urandom);
      m_ready = 1'($urandom_range(0, 2) == 0);
      sys_rst = 1'($urandom_range(0, 60) == 0);
      cycle();
    end
    sys_rst = 1'b0;
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
